// File: rtl/mips_core_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mips_core_pkg : shared register-image, checkpoint FSM state and tag types.
// Revision: 1.0
// ---------------------------------------------------------------------------
package mips_core_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int NUM_REGS   = 32;

  typedef logic [NUM_REGS-1:0][DATA_WIDTH-1:0] reg_image_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESTORE = 2'd1,
    ACK     = 2'd2
  } ckpt_state_e;

  // Width of a checkpoint tag for a given slot count (minimum 1 bit).
  function automatic int ckpt_tag_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_checkpoint_unit_fsm.sv
`default_nettype none
// ---------------------------------------------------------------------------
// snapshot_restore_fsm : restore handshake with reg_file (IDLE/RESTORE/ACK).
// Revision: 1.0
// ---------------------------------------------------------------------------
module snapshot_restore_fsm
  import mips_core_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic        i_rf_done,
  output ckpt_state_e o_state,
  output logic        o_recover_snapshot,
  output logic        o_recovery_done_ack,
  output logic        o_recovery_busy
);

  ckpt_state_e r_state;
  ckpt_state_e w_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Outputs decode only the registered state, so an async reset drops them at once.
  always_comb begin
    w_next              = r_state;
    o_recover_snapshot  = 1'b0;
    o_recovery_done_ack = 1'b0;
    o_recovery_busy     = 1'b1;
    case (r_state)
      IDLE: begin
        o_recovery_busy = 1'b0;
        if (i_start) w_next = RESTORE;
      end
      RESTORE: begin
        o_recover_snapshot = 1'b1;
        if (i_rf_done) w_next = ACK;
      end
      ACK: begin
        o_recovery_done_ack = 1'b1;
        if (!i_rf_done) w_next = IDLE;
      end
      default: begin
        w_next          = IDLE;
        o_recovery_busy = 1'b0;
      end
    endcase
  end

  assign o_state = r_state;

endmodule
`default_nettype wire

// File: rtl/reg_checkpoint_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// reg_checkpoint_unit : circular buffer of register-file checkpoints with
// misprediction restore. Optional macro CKPT_WB_BYPASS_EN merges the
// same-cycle write-back into a captured image.
// Revision: 1.0
// ---------------------------------------------------------------------------
module reg_checkpoint_unit
  import mips_core_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int TAG_W = ckpt_tag_width(DEPTH),
  localparam int CNT_W = TAG_W + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_ckpt_req,
  output logic [TAG_W-1:0]      o_ckpt_tag,
  output logic                  o_ckpt_full,
  output logic                  o_ckpt_empty,
  input  logic                  i_resolve_valid,
  input  logic                  i_resolve_mispredict,
  input  reg_image_t            i_regs_in,
  input  logic                  i_wb_uses_rw,
  input  logic [4:0]            i_wb_rw_addr,
  input  logic [DATA_WIDTH-1:0] i_wb_rw_data,
  output logic                  o_recover_snapshot,
  output reg_image_t            o_regs_snapshot,
  input  logic                  i_rf_done,
  output logic                  o_recovery_done_ack,
  output logic                  o_recovery_busy
);

  reg_image_t       r_slots [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [TAG_W-1:0] r_head;
  logic [TAG_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic [TAG_W-1:0] r_rec_idx;

  ckpt_state_e w_state;
  logic        w_idle;
  logic        w_head_valid;
  logic        w_mispredict;
  logic        w_resolve_ok;
  logic        w_capture;
  reg_image_t  w_capture_img;

  assign o_ckpt_full  = (r_count == CNT_W'(DEPTH));
  assign o_ckpt_empty = (r_count == '0);
  assign o_ckpt_tag   = r_tail;

  assign w_idle       = (w_state == IDLE);
  // The head slot is valid exactly when the buffer is non-empty.
  assign w_head_valid = r_valid[r_head];
  assign w_mispredict = i_resolve_valid && i_resolve_mispredict && w_idle && w_head_valid;
  assign w_resolve_ok = i_resolve_valid && !i_resolve_mispredict && w_idle && w_head_valid;
  assign w_capture    = i_ckpt_req && !o_ckpt_full && w_idle &&
                        !(i_resolve_valid && i_resolve_mispredict);

`ifdef CKPT_WB_BYPASS_EN
  always_comb begin
    w_capture_img = i_regs_in;
    if (i_wb_uses_rw && (i_wb_rw_addr != 5'd0)) begin
      w_capture_img[i_wb_rw_addr] = i_wb_rw_data;
    end
    w_capture_img[0] = '0;
  end
`else
  logic w_unused_wb;
  assign w_unused_wb = ^{i_wb_uses_rw, i_wb_rw_addr, i_wb_rw_data};

  always_comb begin
    w_capture_img    = i_regs_in;
    w_capture_img[0] = '0;
  end
`endif

  // Slot payload is deliberately not reset; only the valid bits are.
  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_slots[r_tail] <= w_capture_img;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= '0;
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_rec_idx <= '0;
    end else if (w_mispredict) begin
      r_rec_idx <= r_head;
      r_valid   <= '0;
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
    end else begin
      if (w_capture) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + TAG_W'(1);
      end
      if (w_resolve_ok) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + TAG_W'(1);
      end
      if (w_capture && !w_resolve_ok) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!w_capture && w_resolve_ok) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  snapshot_restore_fsm u_fsm (
    .clk                 (clk),
    .rst_n               (rst_n),
    .i_start             (w_mispredict),
    .i_rf_done           (i_rf_done),
    .o_state             (w_state),
    .o_recover_snapshot  (o_recover_snapshot),
    .o_recovery_done_ack (o_recovery_done_ack),
    .o_recovery_busy     (o_recovery_busy)
  );

  assign o_regs_snapshot = o_recover_snapshot ? r_slots[r_rec_idx] : '0;

endmodule
`default_nettype wire

// File: tb/tb_reg_checkpoint_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_reg_checkpoint_unit : directed self-checking bench for reg_checkpoint_unit.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_reg_checkpoint_unit;
  import mips_core_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ckpt_req;
  logic [1:0]  ckpt_tag;
  logic        ckpt_full;
  logic        ckpt_empty;
  logic        resolve_valid;
  logic        resolve_mispredict;
  reg_image_t  regs_in;
  logic        wb_uses_rw;
  logic [4:0]  wb_rw_addr;
  logic [31:0] wb_rw_data;
  logic        recover_snapshot;
  reg_image_t  regs_snapshot;
  logic        rf_done;
  logic        recovery_done_ack;
  logic        recovery_busy;

  int n_pass  = 0;
  int n_total = 0;

  reg_checkpoint_unit #(.DEPTH(DEPTH)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .i_ckpt_req           (ckpt_req),
    .o_ckpt_tag           (ckpt_tag),
    .o_ckpt_full          (ckpt_full),
    .o_ckpt_empty         (ckpt_empty),
    .i_resolve_valid      (resolve_valid),
    .i_resolve_mispredict (resolve_mispredict),
    .i_regs_in            (regs_in),
    .i_wb_uses_rw         (wb_uses_rw),
    .i_wb_rw_addr         (wb_rw_addr),
    .i_wb_rw_data         (wb_rw_data),
    .o_recover_snapshot   (recover_snapshot),
    .o_regs_snapshot      (regs_snapshot),
    .i_rf_done            (rf_done),
    .o_recovery_done_ack  (recovery_done_ack),
    .o_recovery_busy      (recovery_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic        rv;
    logic        rm;
    logic        rf;
    logic [31:0] r5;
    logic [1:0]  tag;
    logic        full;
    logic        empty;
    logic        busy;
    logic        rs;
    logic        ack;
    logic [31:0] snap5;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  task automatic clear_inputs();
    ckpt_req           = 1'b0;
    resolve_valid      = 1'b0;
    resolve_mispredict = 1'b0;
    regs_in            = '0;
    wb_uses_rw         = 1'b0;
    wb_rw_addr         = 5'd0;
    wb_rw_data         = 32'd0;
    rf_done            = 1'b0;
  endtask

  task automatic drive(input logic req_i, input logic rv_i, input logic rm_i, input logic [31:0] r5_i);
    @(negedge clk);
    clear_inputs();
    ckpt_req           = req_i;
    resolve_valid      = rv_i;
    resolve_mispredict = rm_i;
    regs_in[5]         = r5_i;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Called one step into a RESTORE cycle; completes the reg_file handshake.
  task automatic finish_restore(input string name);
    int k;
    rf_done = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!recovery_done_ack && k < 10);
    #1;
    chk({name, " ack"}, 32'(recovery_done_ack), 32'd1);
    rf_done = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (recovery_busy && k < 10);
    #1;
    chk({name, " idle"}, 32'(recovery_busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp_r7;
    rst_n = 1'b0;
    clear_inputs();
    #1;
    chk("reset busy", 32'(recovery_busy), 32'd0);
    chk("reset empty", 32'(ckpt_empty), 32'd1);
    do_reset();
    #1;
    chk("reset tag", 32'(ckpt_tag), 32'd0);
    chk("reset full", 32'(ckpt_full), 32'd0);
    chk("reset rs", 32'(recover_snapshot), 32'd0);
    chk("reset ack", 32'(recovery_done_ack), 32'd0);
    chk("reset snap", 32'(|regs_snapshot), 32'd0);

    // Single restore: req rv rm rf r5 | tag full empty busy rs ack snap5
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h1234, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'hFFFF, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h1234};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h1234};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h5555, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h5555, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};

    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].req, vecs[i].rv, vecs[i].rm, vecs[i].r5);
      rf_done = vecs[i].rf;
      #1;
      chk($sformatf("v%0d tag", i),   32'(ckpt_tag),          32'(vecs[i].tag));
      chk($sformatf("v%0d full", i),  32'(ckpt_full),         32'(vecs[i].full));
      chk($sformatf("v%0d empty", i), 32'(ckpt_empty),        32'(vecs[i].empty));
      chk($sformatf("v%0d busy", i),  32'(recovery_busy),     32'(vecs[i].busy));
      chk($sformatf("v%0d rs", i),    32'(recover_snapshot),  32'(vecs[i].rs));
      chk($sformatf("v%0d ack", i),   32'(recovery_done_ack), 32'(vecs[i].ack));
      chk($sformatf("v%0d snap5", i), regs_snapshot[5],       vecs[i].snap5);
    end

    // Fill, drop on full, wrap, restore slot 2.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b0, 32'h100 + 32'(i));
      #1;
      chk($sformatf("fill tag%0d", i), 32'(ckpt_tag), 32'(i));
    end
    drive(1'b1, 1'b0, 1'b0, 32'hDEAD);
    #1;
    chk("fill full", 32'(ckpt_full), 32'd1);
    chk("fill wrap tag", 32'(ckpt_tag), 32'd0);
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    #1;
    chk("dropped 5th full", 32'(ckpt_full), 32'd1);
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    #1;
    chk("resolve1 full", 32'(ckpt_full), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'h200);
    #1;
    chk("reuse tag0", 32'(ckpt_tag), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'h201);
    #1;
    chk("reuse tag1", 32'(ckpt_tag), 32'd1);
    drive(1'b0, 1'b1, 1'b1, 32'h0);
    #1;
    chk("refill full", 32'(ckpt_full), 32'd1);
    @(negedge clk);
    clear_inputs();
    #1;
    chk("wrap restore rs", 32'(recover_snapshot), 32'd1);
    chk("wrap restore r5", regs_snapshot[5], 32'h102);
    finish_restore("wrap");
    chk("wrap empty", 32'(ckpt_empty), 32'd1);

    // Capture plus correct resolve keeps count at 2.
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 32'h1);
    drive(1'b1, 1'b0, 1'b0, 32'h2);
    drive(1'b1, 1'b1, 1'b0, 32'h3);
    #1;
    chk("simul tag", 32'(ckpt_tag), 32'd2);
    drive(1'b1, 1'b0, 1'b0, 32'h4);
    #1;
    chk("simul count2 full", 32'(ckpt_full), 32'd0);
    chk("simul tail", 32'(ckpt_tag), 32'd3);
    drive(1'b1, 1'b0, 1'b0, 32'h5);
    #1;
    chk("simul count3 full", 32'(ckpt_full), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    chk("simul count4 full", 32'(ckpt_full), 32'd1);

    // Capture plus mispredict: capture dropped.
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 32'h7);
    drive(1'b1, 1'b1, 1'b1, 32'h8);
    @(negedge clk);
    clear_inputs();
    #1;
    chk("cap+misp empty", 32'(ckpt_empty), 32'd1);
    chk("cap+misp r5", regs_snapshot[5], 32'h7);
    finish_restore("cap+misp");
    chk("cap+misp tag", 32'(ckpt_tag), 32'd0);
    chk("cap+misp empty after", 32'(ckpt_empty), 32'd1);

    // Write-back bypass.
`ifdef CKPT_WB_BYPASS_EN
    exp_r7 = 32'hAA;
`else
    exp_r7 = 32'h11;
`endif
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    regs_in[7] = 32'h11;
    regs_in[0] = 32'h99;
    wb_uses_rw = 1'b1;
    wb_rw_addr = 5'd7;
    wb_rw_data = 32'hAA;
    drive(1'b0, 1'b1, 1'b1, 32'h0);
    @(negedge clk);
    clear_inputs();
    #1;
    chk("bypass r7", regs_snapshot[7], exp_r7);
    chk("bypass r0", regs_snapshot[0], 32'h0);
    finish_restore("bypass");
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    regs_in[0] = 32'h99;
    wb_uses_rw = 1'b1;
    wb_rw_addr = 5'd0;
    wb_rw_data = 32'h77;
    drive(1'b0, 1'b1, 1'b1, 32'h0);
    @(negedge clk);
    clear_inputs();
    #1;
    chk("wb r0 zero", regs_snapshot[0], 32'h0);
    finish_restore("wb r0");

    // Reset asserted in ACK.
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 32'h9);
    drive(1'b0, 1'b1, 1'b1, 32'h0);
    @(negedge clk);
    clear_inputs();
    rf_done = 1'b1;
    @(negedge clk);
    #1;
    chk("mid ack before rst", 32'(recovery_done_ack), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid rst ack", 32'(recovery_done_ack), 32'd0);
    chk("mid rst rs", 32'(recover_snapshot), 32'd0);
    chk("mid rst busy", 32'(recovery_busy), 32'd0);
    chk("mid rst snap", 32'(|regs_snapshot), 32'd0);
    chk("mid rst empty", 32'(ckpt_empty), 32'd1);
    rf_done = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 32'hA);
    #1;
    chk("post rst tag", 32'(ckpt_tag), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    chk("post rst capture tag", 32'(ckpt_tag), 32'd1);
    chk("post rst capture empty", 32'(ckpt_empty), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
